uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart TX byte interface (tx_byte/tx_req/tx_busy) between NUM_CLIENTS requesters.
//  Each client streams bytes with a valid/ready handshake and marks its last byte; grant is held per packet.
//  Sits between on-chip byte producers (debug, status, echo) and the uart instance (25 MHz system clock).
// PARAMETERS
//  NUM_CLIENTS    4      number of requesters (2..8)
//  CLIENT_W       2      width of the client index; equals clog2(NUM_CLIENTS)
//  MAX_PKT_BYTES  16     forced grant release after this many data bytes (1..255)
//  TAG_BASE       8'hF0  tag byte base; sent as TAG_BASE | client index (only with UART_ARB_TAG_EN)
// PORTS
//  clk           in   1              system clock
//  reset         in   1              synchronous, active-high
//  cl_valid      in   NUM_CLIENTS    client i has a byte on cl_data[8i+7:8i]
//  cl_data       in   8*NUM_CLIENTS  packed client bytes
//  cl_last       in   NUM_CLIENTS    qualifies cl_data: this byte ends the packet
//  cl_ready      out  NUM_CLIENTS    byte accepted on the edge where valid & ready
//  tx_byte       out  8              to uart tx_byte
//  tx_req        out  1              to uart tx_req; one-cycle pulse
//  tx_busy       in   1              from uart tx_busy
//  grant_id      out  CLIENT_W       index of the current/last granted client
//  grant_active  out  1              a packet is locked to grant_id
//  pkt_trunc     out  1              one-cycle pulse: grant force-released at MAX_PKT_BYTES
// BEHAVIOUR
//  Reset values: cl_ready=0, tx_byte=0, tx_req=0, grant_id=NUM_CLIENTS-1, grant_active=0, pkt_trunc=0.
//  Reset state: ARB, byte count=0. Reset mid-frame aborts immediately; the uart is reset on the same signal.
//  States: ARB, TAG (only with UART_ARB_TAG_EN), LOAD, REQ, WAIT_HI, WAIT_LO.
//  ARB: if any cl_valid, pick a winner round-robin starting at grant_id+1 (wrap at NUM_CLIENTS-1 -> 0).
//    Register grant_id, set grant_active=1, clear count, go to LOAD (or TAG). Otherwise stay in ARB.
//  LOAD: cl_ready[grant_id] = cl_valid[grant_id]; all other cl_ready bits stay 0. cl_ready is combinational.
//    On a transfer: tx_byte<=data, last_q<=cl_last, count<=count+1, go to REQ.
//    If the granted client drops valid mid-packet, wait in LOAD with the grant held; other clients are blocked.
//  REQ: tx_req=1 for exactly this cycle, then go to WAIT_HI.
//  WAIT_HI: wait for tx_busy=1 (the uart raises it the cycle after the request), then go to WAIT_LO.
//  WAIT_LO: wait for tx_busy=0, then:
//    - last_q=1: grant_active<=0, go to ARB.
//    - last_q=0 and count==MAX_PKT_BYTES: grant_active<=0, pkt_trunc=1 for one cycle, go to ARB.
//    - otherwise go to LOAD.
//  tx_req is never asserted while tx_busy=1; at most one byte is outstanding at the uart.
//  Latency: client valid in ARB at edge N -> ready high in cycle N+1 -> tx_req high in cycle N+2.
//  Back-to-back: 3 cycles from the uart tx_busy fall to the next tx_req (WAIT_LO -> LOAD -> REQ).
//  Fairness: after release, the releasing client has lowest priority. A sole requester is re-granted immediately.
//  Count is 8 bits wide and cleared at each grant; count never exceeds MAX_PKT_BYTES.
//  cl_data and cl_last are don't-care while the matching cl_valid=0.
// CONFIGURATION
//  UART_ARB_TAG_EN defined:
//    ARB goes to TAG after each grant.
//    TAG loads tx_byte = TAG_BASE | grant_id and runs REQ/WAIT_HI/WAIT_LO without consuming client data, then goes to LOAD.
//    The tag is not counted toward MAX_PKT_BYTES.
//  UART_ARB_TAG_EN undefined:
//    TAG state absent; ARB goes directly to LOAD; the wire stream carries client bytes only.
// TESTING
//  1 Single client: client 0 sends {8'h41 last=0, 8'h42 last=1} -> tx_req pulses twice, tx_byte 41 then 42,
//    grant_active falls after the 2nd tx_busy fall.
//  2 Round-robin: clients 1 and 2 each hold a 1-byte packet (8'h11, 8'h22) from reset -> order 11 then 22;
//    client 1 re-requests during the 22 frame -> served after 22.
//  3 Packet lock: client 0 sends a 3-byte packet (last on byte 3) while client 3 requests
//    -> all 3 bytes of client 0 are sent before any byte of client 3.
//  4 Truncation: MAX_PKT_BYTES=4, client 2 sends 6 bytes with no last -> 4 bytes sent, pkt_trunc pulses once,
//    remaining 2 bytes sent under a new grant.
//  5 Reset mid-frame: reset asserted in WAIT_LO -> next cycle tx_req=0, cl_ready=0, grant_active=0;
//    no duplicate or lost tx_req after release.
//  6 UART_ARB_TAG_EN: client 1 sends a 1-byte packet 8'h55 -> wire bytes F1 then 55, count excludes the tag.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX byte port between NUM_CLIENTS packet streams.
// Define UART_ARB_TAG_EN to prefix every granted packet with a tag byte (TAG_BASE | client index).
module uart_tx_arbiter #(
    parameter int         NUM_CLIENTS   = 4,
    parameter int         CLIENT_W      = 2,
    parameter int         MAX_PKT_BYTES = 16,
    parameter logic [7:0] TAG_BASE      = 8'hF0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CLIENTS-1:0]   cl_valid,
    input  logic [8*NUM_CLIENTS-1:0] cl_data,
    input  logic [NUM_CLIENTS-1:0]   cl_last,
    output logic [NUM_CLIENTS-1:0]   cl_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_req,
    input  logic                     tx_busy,
    output logic [CLIENT_W-1:0]      grant_id,
    output logic                     grant_active,
    output logic                     pkt_trunc
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_PKT_BYTES);

    typedef enum logic [2:0] {
        ST_ARB,
`ifdef UART_ARB_TAG_EN
        ST_TAG,
`endif
        ST_LOAD,
        ST_REQ,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          count;
    logic                last_q;
    logic                tag_phase;

    logic                rr_found;
    logic [CLIENT_W-1:0] rr_winner;
    logic [CLIENT_W-1:0] rr_idx;

    logic                start_grant;
    logic                take_byte;
    logic                load_tag;
    logic                release_grant;
    logic                trunc_hit;

    logic [7:0]          cur_data;
    logic                cur_last;

    assign cur_data = cl_data[{grant_id, 3'b000} +: 8];
    assign cur_last = cl_last[grant_id];

    // Search starts one past the last grant, so the releasing client is checked last
    // and a sole requester still wins on the final step of the scan.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = grant_id;
        rr_idx    = grant_id;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            rr_idx = CLIENT_W'((int'(grant_id) + k) % NUM_CLIENTS);
            if (!rr_found && cl_valid[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        cl_ready      = '0;
        tx_req        = 1'b0;
        start_grant   = 1'b0;
        take_byte     = 1'b0;
        load_tag      = 1'b0;
        release_grant = 1'b0;
        trunc_hit     = 1'b0;
        case (state)
            ST_ARB: begin
                if (rr_found) begin
                    start_grant = 1'b1;
`ifdef UART_ARB_TAG_EN
                    state_next  = ST_TAG;
`else
                    state_next  = ST_LOAD;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                load_tag   = 1'b1;
                state_next = ST_REQ;
            end
`endif
            ST_LOAD: begin
                cl_ready[grant_id] = cl_valid[grant_id];
                if (cl_valid[grant_id]) begin
                    take_byte  = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                tx_req     = 1'b1;
                state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (tag_phase) begin
                        state_next = ST_LOAD;
                    end else if (last_q) begin
                        release_grant = 1'b1;
                        state_next    = ST_ARB;
                    end else if (count == MAX_CNT) begin
                        release_grant = 1'b1;
                        trunc_hit     = 1'b1;
                        state_next    = ST_ARB;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ARB;
            grant_id     <= CLIENT_W'(NUM_CLIENTS - 1);
            grant_active <= 1'b0;
            count        <= 8'd0;
            last_q       <= 1'b0;
            tx_byte      <= 8'd0;
            pkt_trunc    <= 1'b0;
        end else begin
            state     <= state_next;
            pkt_trunc <= trunc_hit;
            if (start_grant) begin
                grant_id     <= rr_winner;
                grant_active <= 1'b1;
                count        <= 8'd0;
            end
            if (load_tag) begin
                tx_byte <= TAG_BASE | 8'(grant_id);
            end
            if (take_byte) begin
                tx_byte <= cur_data;
                last_q  <= cur_last;
                count   <= count + 8'd1;
            end
            if (release_grant) begin
                grant_active <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_TAG_EN
    // Set from grant until the first data byte: the frame in flight is the tag,
    // which neither ends the packet nor counts toward the truncation limit.
    logic tag_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= 1'b0;
        end else if (start_grant) begin
            tag_q <= 1'b1;
        end else if (take_byte) begin
            tag_q <= 1'b0;
        end
    end
    assign tag_phase = tag_q;
`else
    assign tag_phase = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, a uart busy model and a tx_req monitor.
module tb_uart_tx_arbiter;

    localparam int         NC    = 4;
    localparam int         CW    = 2;
    localparam int         MAXB  = 4;
    localparam logic [7:0] TBASE = 8'hF0;
    localparam int         FRAME = 4;
`ifdef UART_ARB_TAG_EN
    localparam int         TAGN  = 1;
`else
    localparam int         TAGN  = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NC-1:0]   cl_valid = '0;
    logic [8*NC-1:0] cl_data = '0;
    logic [NC-1:0]   cl_last = '0;
    logic [NC-1:0]   cl_ready;
    logic [7:0]      tx_byte;
    logic            tx_req;
    logic            tx_busy = 1'b0;
    logic [CW-1:0]   grant_id;
    logic            grant_active;
    logic            pkt_trunc;

    uart_tx_arbiter #(
        .NUM_CLIENTS  (NC),
        .CLIENT_W     (CW),
        .MAX_PKT_BYTES(MAXB),
        .TAG_BASE     (TBASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cl_valid    (cl_valid),
        .cl_data     (cl_data),
        .cl_last     (cl_last),
        .cl_ready    (cl_ready),
        .tx_byte     (tx_byte),
        .tx_req      (tx_req),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_active(grant_active),
        .pkt_trunc   (pkt_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         client;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] cq[NC][$];
    logic [NC-1:0] fire = '0;
    logic [8:0] drv_e;
    int checks = 0;
    int errors = 0;
    int n_req = 0;
    int n_trunc = 0;
    int busy_cnt = 0;
    bit pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic exp_push(input int c, input logic [7:0] d);
        exp_t e;
        e.client = c;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_tag(input int c);
`ifdef UART_ARB_TAG_EN
        exp_push(c, TBASE | 8'(c));
`endif
    endtask

    // Client driver: pop a byte after each accepted handshake, present the next one.
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (fire[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        end
        for (int i = 0; i < NC; i++) begin
            if (cq[i].size() > 0) begin
                drv_e = cq[i][0];
                cl_valid[i]       = 1'b1;
                cl_data[8*i +: 8] = drv_e[7:0];
                cl_last[i]        = drv_e[8];
            end else begin
                cl_valid[i]       = 1'b0;
                cl_data[8*i +: 8] = 8'h00;
                cl_last[i]        = 1'b0;
            end
        end
        #1;
        for (int i = 0; i < NC; i++) fire[i] = cl_valid[i] & cl_ready[i] & ~reset;
    end

    // Uart model (busy rises the cycle after a request, holds FRAME cycles) plus tx monitor.
    always @(negedge clk) begin
        if (reset) begin
            pend     = 1'b0;
            busy_cnt = 0;
            tx_busy  = 1'b0;
        end else begin
            if (tx_req) begin
                n_req++;
                check("req_while_busy", tx_busy, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_req: got byte %0h, expected none (t=%0t)", tx_byte, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tx_byte", tx_byte, e.data);
                    check("grant_id_at_req", grant_id, e.client);
                end
            end
            if (pkt_trunc) n_trunc++;
            if (pend) begin
                pend     = 1'b0;
                busy_cnt = FRAME;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            if (tx_req) pend = 1'b1;
            tx_busy = (busy_cnt > 0);
        end
    end

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for the scoreboard to empty and the final uart frame to finish; exits in the fall cycle.
    task automatic wait_drain(input string name);
        int stage = 0;
        int n = 0;
        while (stage < 3 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
            case (stage)
                0: if (exp_q.size() == 0) stage = 1;
                1: if (tx_busy) stage = 2;
                2: if (!tx_busy) stage = 3;
                default: ;
            endcase
        end
        check({name, "_drained"}, stage, 3);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int n;
        int req0;
        int trunc0;

        // Reset values
        assert_reset();
        @(negedge clk);
        #2;
        check("rst_cl_ready", cl_ready, '0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_grant_id", grant_id, NC - 1);
        check("rst_grant_active", grant_active, 1'b0);
        check("rst_pkt_trunc", pkt_trunc, 1'b0);
        release_reset();
        repeat (2) @(negedge clk);

        // 1: single client, two bytes; latency and back-to-back timing
        @(posedge clk);
        #1;
        exp_tag(0);
        exp_push(0, 8'h41);
        exp_push(0, 8'h42);
        cq[0].push_back({1'b0, 8'h41});
        cq[0].push_back({1'b1, 8'h42});
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!cl_valid[0] && n < 20);
        lat = 0;
        do begin @(negedge clk); #2; lat++; end while (!tx_req && lat < 20);
        check("t1_valid_to_req", lat, 2);
        n = 0;
        while (!tx_busy && n < 20) begin @(negedge clk); #2; n++; end
        while (tx_busy && n < 40) begin @(negedge clk); #2; n++; end
        // Fall cycle is WAIT_LO, then LOAD, then REQ: tx_req in the third cycle.
        lat = 0;
        do begin @(negedge clk); #2; lat++; end while (!tx_req && lat < 20);
        check("t1_busy_fall_to_req", lat, 2);
        wait_drain("t1");
        check("t1_gact_in_fall_cycle", grant_active, 1'b1);
        @(negedge clk);
        #2;
        check("t1_gact_after_fall", grant_active, 1'b0);

        // 2: round-robin from reset, re-request served after the other client
        assert_reset();
        cq[1].push_back({1'b1, 8'h11});
        cq[2].push_back({1'b1, 8'h22});
        exp_tag(1);
        exp_push(1, 8'h11);
        exp_tag(2);
        exp_push(2, 8'h22);
        exp_tag(1);
        exp_push(1, 8'h13);
        release_reset();
        n = 0;
        while (exp_q.size() > 1 + TAGN && n < 200) begin @(negedge clk); #2; n++; end
        while (!tx_busy && n < 220) begin @(negedge clk); #2; n++; end
        check("t2_grant_during_22", grant_id, 2);
        cq[1].push_back({1'b1, 8'h13});
        wait_drain("t2");

        // 3: packet lock, granted client stalls mid-packet while client 3 waits
        assert_reset();
        cq[0].push_back({1'b0, 8'hA0});
        cq[3].push_back({1'b0, 8'hB0});
        cq[3].push_back({1'b1, 8'hB1});
        exp_tag(0);
        exp_push(0, 8'hA0);
        exp_push(0, 8'hA1);
        exp_push(0, 8'hA2);
        exp_tag(3);
        exp_push(3, 8'hB0);
        exp_push(3, 8'hB1);
        release_reset();
        n = 0;
        while (exp_q.size() > 4 + TAGN && n < 200) begin @(negedge clk); #2; n++; end
        repeat (10) @(negedge clk);
        #2;
        check("t3_stall_ready3", cl_ready[3], 1'b0);
        check("t3_stall_gid", grant_id, 0);
        check("t3_stall_gact", grant_active, 1'b1);
        cq[0].push_back({1'b0, 8'hA1});
        cq[0].push_back({1'b1, 8'hA2});
        wait_drain("t3");

        // 4: truncation at MAX_PKT_BYTES, remainder under a fresh grant
        assert_reset();
        trunc0 = n_trunc;
        exp_tag(2);
        for (int b = 0; b < 4; b++) exp_push(2, 8'h60 + 8'(b));
        exp_tag(2);
        exp_push(2, 8'h64);
        exp_push(2, 8'h65);
        for (int b = 0; b < 6; b++) cq[2].push_back({1'b0, 8'h60 + 8'(b)});
        release_reset();
        wait_drain("t4");
        repeat (3) @(negedge clk);
        #2;
        check("t4_trunc_pulses", n_trunc - trunc0, 1);
        check("t4_grant_held", grant_active, 1'b1);
        check("t4_grant_id", grant_id, 2);

        // 5: reset in WAIT_LO aborts the frame; the pending byte goes out exactly once
        assert_reset();
        cq[0].push_back({1'b0, 8'h71});
        cq[0].push_back({1'b1, 8'h72});
        exp_tag(0);
        exp_push(0, 8'h71);
        release_reset();
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin @(negedge clk); #2; n++; end
        while (!tx_busy && n < 220) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("t5_tx_req", tx_req, 1'b0);
        check("t5_cl_ready", cl_ready, '0);
        check("t5_gact", grant_active, 1'b0);
        check("t5_gid", grant_id, NC - 1);
        check("t5_tx_byte", tx_byte, 8'h00);
        exp_tag(0);
        exp_push(0, 8'h72);
        req0 = n_req;
        release_reset();
        wait_drain("t5");
        repeat (20) @(negedge clk);
        #2;
        check("t5_req_count", n_req - req0, 1 + TAGN);
        check("t5_gact_end", grant_active, 1'b0);

        // 6: one-byte packet from client 1 (tag prefix when enabled)
        assert_reset();
        release_reset();
        req0 = n_req;
        exp_tag(1);
        exp_push(1, 8'h55);
        cq[1].push_back({1'b1, 8'h55});
        wait_drain("t6");
        repeat (5) @(negedge clk);
        #2;
        check("t6_req_count", n_req - req0, 1 + TAGN);
        check("t6_gact_end", grant_active, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
